ddfs_sweep_controller: RTL and testbench
========================================

Name: ddfs_sweep_controller

Overview:
Sequencer that drives the CORDIC DDFS core's FCW and clear inputs to generate tones, linear frequency sweeps, repeating sweeps and triangle chirps.
Accepts one sweep descriptor at a time over a valid/ready handshake.
Holds each frequency for a programmable dwell, then steps FCW phase-continuously (DDFS accumulator is not cleared between steps).
Flags when the DDFS pipeline output is valid.

Parameters:
FCW_W, 10, width of FCW fields and output; matches DDFS FCW input.
DWELL_W, 16, width of dwell counter and cfg_dwell.
FCW_MAX, 359, largest legal FCW; larger values are clamped at capture.
FLUSH_CYC, 2, cycles ddfs_clear is held high before a sweep starts (≥1).
PIPE_LAT, 17, DDFS latency from clear release to first valid sample (phase register + stage-0 register + 15 CORDIC stages).

Ports:
clock_100_MHz  in  1  single clock.
clear_DDFS  in  1  reset; synchronous, active-high.
cfg_valid  in  1  descriptor offered.
cfg_ready  out  1  high only in IDLE and when clear_DDFS=0.
cfg_start_fcw  in  FCW_W  first FCW.
cfg_stop_fcw  in  FCW_W  end FCW.
cfg_step  in  FCW_W  step magnitude; 0 means fixed tone.
cfg_dwell  in  DWELL_W  cycles per frequency; 0 is treated as 1.
cfg_mode  in  2  00 single, 01 repeat, 10 triangle, 11 fixed tone.
abort  in  1  stop the current sweep.
FCW  out  FCW_W  drives DDFS FCW.
ddfs_clear  out  1  drives DDFS clear_DDFS.
wave_valid  out  1  DDFS COSINE/SINE outputs valid.
busy  out  1  state is not IDLE.
sweep_done  out  1  one-cycle pulse at the end of a single-mode sweep.
step_count  out  16  FCW updates since the flush; wraps.

Behaviour:
- Reset (clear_DDFS=1): state=IDLE, FCW=0, ddfs_clear=1, wave_valid=0, busy=0, sweep_done=0, step_count=0, cfg_ready=0.
- Reset dominates every other input in every state.
- States: IDLE, FLUSH, RUN, DONE.
- IDLE: ddfs_clear=1, FCW=0, cfg_ready=1, abort ignored.
  - cfg_valid & cfg_ready at cycle T: latch all fields, then go to FLUSH.
  - Start and stop are clamped to FCW_MAX.
  - Direction is down if start>stop, otherwise up.
  - Fixed tone applies if mode=11, step=0, or start=stop.
- FLUSH: FCW=start and ddfs_clear=1 during cycles T+1..T+FLUSH_CYC; then RUN.
- RUN: ddfs_clear=0 from T+FLUSH_CYC+1.
  - Latency counter: wave_valid=1 from cycle T+FLUSH_CYC+1+PIPE_LAT; stays high until leaving RUN.
  - Dwell counter starts on the first RUN cycle. FCW updates after each dwell expiry; step_count increments on each update.
  - Next FCW = current ± step, saturated at stop.
  - No overflow past FCW_MAX or below 0: saturation to stop precedes the update.
- End of dwell at stop:
  - single: go to DONE.
  - repeat: FCW=start (no flush, phase-continuous), step_count=0.
  - triangle: reverse direction and step toward start; reverse again at start; runs until abort.
  - fixed tone: FCW never changes and DONE is never reached.
- DONE: exactly one cycle. sweep_done=1, ddfs_clear=1, wave_valid=0, FCW=0, busy=1; then IDLE (busy=0).
- abort in FLUSH/RUN/DONE: next cycle is IDLE with IDLE outputs; no sweep_done pulse. Abort in DONE still returns to IDLE with the pulse already issued.
- Configuration inputs are ignored outside IDLE.
- Reset mid-sweep: next cycle shows reset values and the descriptor is discarded.

Test Plan:
- Single sweep: start=10, stop=40, step=10, dwell=8, mode=00, accepted at cycle 0.
  -> ddfs_clear=1 at cycles 1-2, 0 from cycle 3.
  -> FCW=10@1, 20@11, 30@19, 40@27.
  -> wave_valid=1 at cycles 20-34; sweep_done pulse at 35; busy=0 and cfg_ready=1 at 36; step_count=3 at 27.
- Overshoot and clamp: start=400, stop=0, step=150, dwell=1, mode=00.
  -> start clamps to 359; direction down.
  -> FCW sequence 359, 209, 59, 0; then DONE.
- Triangle: start=100, stop=120, step=10, dwell=2, mode=10.
  -> FCW 100, 110, 120, 110, 100, 110, ... with no ddfs_clear pulse after the flush.
  -> abort mid-run -> IDLE next cycle, ddfs_clear=1, wave_valid=0, no sweep_done.
- Fixed tone and repeat:
  - step=0, mode=01, start=50 -> FCW stays 50 for 1000 cycles and busy stays 1.
  - mode=01, start=0, stop=20, step=10, dwell=1 -> FCW 0, 10, 20, 0, 10, ... and step_count resets to 0 at each wrap.
- Handshake corner: cfg_valid held high through a sweep -> only one capture, at the IDLE cycle; a second capture follows the cycle after return to IDLE. cfg_dwell=0 behaves identically to 1.
- Reset mid-RUN at cycle 12 -> cycle 13 shows FCW=0, ddfs_clear=1, busy=0, wave_valid=0, step_count=0; cfg_ready=1 once clear_DDFS deasserts.

Source files
------------

// File: rtl/ddfs_sweep_controller_if.sv
// Sweep descriptor channel: one frequency program per valid/ready transfer.
// Fields are only sampled on the cycle the transfer completes.
interface ddfs_sweep_controller_if #(
  parameter int FCW_W   = 10,
  parameter int DWELL_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FCW_W-1:0]   cfg_start_fcw;
  logic [FCW_W-1:0]   cfg_stop_fcw;
  logic [FCW_W-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_mode;

  modport master (
    output cfg_valid, cfg_start_fcw, cfg_stop_fcw, cfg_step, cfg_dwell, cfg_mode,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_start_fcw, cfg_stop_fcw, cfg_step, cfg_dwell, cfg_mode,
    output cfg_ready
  );
endinterface

// File: rtl/ddfs_sweep_controller.sv
// Sweep sequencer for the CORDIC DDFS: tones, linear/repeating sweeps and triangle chirps.
// FCW steps one cycle after each dwell expiry; cfg_ready only in IDLE, so descriptors wait while a sweep runs.
module ddfs_sweep_controller #(
  parameter int FCW_W     = 10,
  parameter int DWELL_W   = 16,
  parameter int FCW_MAX   = 359,
  parameter int FLUSH_CYC = 2,
  parameter int PIPE_LAT  = 17
) (
  input  logic                   clock_100_MHz,
  input  logic                   clear_DDFS,
  ddfs_sweep_controller_if.slave cfg,
  input  logic                   abort,
  output logic [FCW_W-1:0]       FCW,
  output logic                   ddfs_clear,
  output logic                   wave_valid,
  output logic                   busy,
  output logic                   sweep_done,
  output logic [15:0]            step_count
);

  localparam int LAT_W = $clog2(PIPE_LAT + 1);
  localparam int FL_W  = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FCW_W-1:0] FCW_MAX_V   = FCW_W'(FCW_MAX);
  localparam logic [1:0]       MODE_SINGLE = 2'b00;
  localparam logic [1:0]       MODE_REPEAT = 2'b01;
  localparam logic [1:0]       MODE_TRI    = 2'b10;
  localparam logic [1:0]       MODE_TONE   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_RUN,
    S_DONE
  } state_t;

  typedef struct packed {
    logic [FCW_W-1:0]   start;
    logic [FCW_W-1:0]   stop;
    logic [FCW_W-1:0]   step;
    logic [DWELL_W-1:0] dwell_m1;
    logic [1:0]         mode;
    logic               fixed;
  } desc_t;

  state_t             state_q, state_d;
  desc_t              desc_q, desc_in;
  logic [FCW_W-1:0]   start_c, stop_c;
  logic [FCW_W-1:0]   fcw_q, tgt_q;
  logic [FCW_W-1:0]   fcw_next, fcw_rev, tgt_rev;
  logic               down_q;
  logic [DWELL_W-1:0] dwell_cnt_q;
  logic [LAT_W-1:0]   lat_cnt_q;
  logic [FL_W-1:0]    flush_cnt_q;
  logic [15:0]        step_cnt_q;
  logic               capture;
  logic               flush_last;
  logic               dwell_exp;
  logic               at_tgt;

  // Saturating move toward tgt; callers guarantee cur is on the correct side of tgt.
  function automatic logic [FCW_W-1:0] step_toward(
    input logic [FCW_W-1:0] cur,
    input logic [FCW_W-1:0] tgt,
    input logic [FCW_W-1:0] stp,
    input logic             dn
  );
    logic [FCW_W-1:0] r;
    if (dn) r = ((cur - tgt) <= stp) ? tgt : cur - stp;
    else    r = ((tgt - cur) <= stp) ? tgt : cur + stp;
    return r;
  endfunction

  always_comb begin
    start_c = (cfg.cfg_start_fcw > FCW_MAX_V) ? FCW_MAX_V : cfg.cfg_start_fcw;
    stop_c  = (cfg.cfg_stop_fcw  > FCW_MAX_V) ? FCW_MAX_V : cfg.cfg_stop_fcw;
    desc_in.start    = start_c;
    desc_in.stop     = stop_c;
    desc_in.step     = cfg.cfg_step;
    desc_in.dwell_m1 = (cfg.cfg_dwell == '0) ? '0 : cfg.cfg_dwell - 1'b1;
    desc_in.mode     = cfg.cfg_mode;
    desc_in.fixed    = (cfg.cfg_mode == MODE_TONE) || (cfg.cfg_step == '0) || (start_c == stop_c);
  end

  assign cfg.cfg_ready = (state_q == S_IDLE) && !clear_DDFS;
  assign flush_last    = (flush_cnt_q == FL_W'(FLUSH_CYC - 1));
  assign dwell_exp     = (dwell_cnt_q == desc_q.dwell_m1);
  assign at_tgt        = (fcw_q == tgt_q);
  assign tgt_rev       = (tgt_q == desc_q.stop) ? desc_q.start : desc_q.stop;
  assign fcw_next      = step_toward(fcw_q, tgt_q, desc_q.step, down_q);
  assign fcw_rev       = step_toward(fcw_q, tgt_rev, desc_q.step, ~down_q);
  assign step_count    = step_cnt_q;

  always_ff @(posedge clock_100_MHz) begin
    if (clear_DDFS) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    FCW        = '0;
    ddfs_clear = 1'b1;
    wave_valid = 1'b0;
    busy       = 1'b1;
    sweep_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (cfg.cfg_valid && !clear_DDFS) begin
          capture = 1'b1;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        FCW = fcw_q;
        if (abort)           state_d = S_IDLE;
        else if (flush_last) state_d = S_RUN;
      end
      S_RUN: begin
        FCW        = fcw_q;
        ddfs_clear = 1'b0;
        wave_valid = (lat_cnt_q == LAT_W'(PIPE_LAT));
        if (abort)
          state_d = S_IDLE;
        else if (dwell_exp && at_tgt && !desc_q.fixed && desc_q.mode == MODE_SINGLE)
          state_d = S_DONE;
      end
      S_DONE: begin
        sweep_done = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_100_MHz) begin
    if (clear_DDFS) begin
      desc_q      <= '0;
      fcw_q       <= '0;
      tgt_q       <= '0;
      down_q      <= 1'b0;
      dwell_cnt_q <= '0;
      lat_cnt_q   <= '0;
      flush_cnt_q <= '0;
      step_cnt_q  <= '0;
    end else begin
      if (capture) begin
        desc_q      <= desc_in;
        fcw_q       <= start_c;
        tgt_q       <= stop_c;
        down_q      <= (start_c > stop_c);
        flush_cnt_q <= '0;
        step_cnt_q  <= '0;
      end
      // Counters held at zero through the flush so the first RUN cycle starts both windows.
      if (state_q == S_FLUSH) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
        dwell_cnt_q <= '0;
        lat_cnt_q   <= '0;
      end
      if (state_q == S_RUN) begin
        if (lat_cnt_q != LAT_W'(PIPE_LAT)) lat_cnt_q <= lat_cnt_q + 1'b1;
        if (dwell_exp) begin
          dwell_cnt_q <= '0;
          if (!desc_q.fixed) begin
            if (!at_tgt) begin
              fcw_q      <= fcw_next;
              step_cnt_q <= step_cnt_q + 1'b1;
            end else if (desc_q.mode == MODE_REPEAT) begin
              fcw_q      <= desc_q.start;
              step_cnt_q <= '0;
            end else if (desc_q.mode == MODE_TRI) begin
              fcw_q      <= fcw_rev;
              tgt_q      <= tgt_rev;
              down_q     <= ~down_q;
              step_cnt_q <= step_cnt_q + 1'b1;
            end
          end
        end else begin
          dwell_cnt_q <= dwell_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ddfs_sweep_controller.sv
// Randomized and directed checks of the sweep controller against a per-cycle trace model.
module tb_ddfs_sweep_controller;
  localparam int FCW_W     = 10;
  localparam int DWELL_W   = 16;
  localparam int FCW_MAX   = 359;
  localparam int FLUSH_CYC = 2;
  localparam int PIPE_LAT  = 17;

  logic               clock_100_MHz = 1'b0;
  logic               clear_DDFS;
  logic               abort;
  logic [FCW_W-1:0]   FCW;
  logic               ddfs_clear;
  logic               wave_valid;
  logic               busy;
  logic               sweep_done;
  logic [15:0]        step_count;

  ddfs_sweep_controller_if #(.FCW_W(FCW_W), .DWELL_W(DWELL_W)) cfg_if ();

  ddfs_sweep_controller #(
    .FCW_W(FCW_W), .DWELL_W(DWELL_W), .FCW_MAX(FCW_MAX),
    .FLUSH_CYC(FLUSH_CYC), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clock_100_MHz(clock_100_MHz),
    .clear_DDFS(clear_DDFS),
    .cfg(cfg_if),
    .abort(abort),
    .FCW(FCW),
    .ddfs_clear(ddfs_clear),
    .wave_valid(wave_valid),
    .busy(busy),
    .sweep_done(sweep_done),
    .step_count(step_count)
  );

  always #5 clock_100_MHz = ~clock_100_MHz;

  typedef struct {
    int fcw;
    bit clr;
    bit wv;
    bit bsy;
    bit dn;
    bit rdy;
    int sc;
    bit sc_chk;
  } rec_t;

  rec_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   obs_clr0, obs_wv_first, obs_wv_last, obs_done, last_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_rec(input int fcw, input bit clr, input bit wv, input bit bsy,
                          input bit dn, input bit rdy, input int sc, input bit sc_chk);
    rec_t r;
    r.fcw = fcw; r.clr = clr; r.wv = wv; r.bsy = bsy;
    r.dn = dn; r.rdy = rdy; r.sc = sc; r.sc_chk = sc_chk;
    exp_q.push_back(r);
  endtask

  // Expected trace from the cycle after capture: the flush, then one entry per RUN cycle.
  task automatic build_model(input int s_in, input int e_in, input int stp, input int dw,
                             input int md, input int run_len);
    int s, e, de, cur, tgt, sc, k, limit;
    bit fixed, term;
    exp_q.delete();
    s     = (s_in > FCW_MAX) ? FCW_MAX : s_in;
    e     = (e_in > FCW_MAX) ? FCW_MAX : e_in;
    de    = (dw == 0) ? 1 : dw;
    fixed = (md == 3) || (stp == 0) || (s == e);
    term  = (md == 0) && !fixed;
    limit = term ? 100000 : run_len;
    for (int i = 0; i < FLUSH_CYC; i++) push_rec(s, 1, 0, 1, 0, 0, 0, 1);
    cur = s; tgt = e; sc = 0; k = 0;
    while (k < limit) begin
      for (int d = 0; d < de; d++) begin
        push_rec(cur, 0, k >= PIPE_LAT, 1, 0, 0, sc, 1);
        k++;
      end
      if (!fixed) begin
        if (cur != tgt) begin
          cur = (tgt > cur) ? ((cur + stp > tgt) ? tgt : cur + stp)
                            : ((cur - stp < tgt) ? tgt : cur - stp);
          sc  = (sc + 1) % 65536;
        end else if (md == 0) begin
          push_rec(0, 1, 0, 1, 1, 0, 0, 0);
          push_rec(0, 1, 0, 0, 0, 1, 0, 0);
          k = limit;
        end else if (md == 1) begin
          cur = s;
          sc  = 0;
        end else begin
          tgt = (tgt == e) ? s : e;
          cur = (tgt > cur) ? ((cur + stp > tgt) ? tgt : cur + stp)
                            : ((cur - stp < tgt) ? tgt : cur - stp);
          sc  = (sc + 1) % 65536;
        end
      end
    end
  endtask

  task automatic check_rec(input rec_t r);
    chk("fcw", FCW, r.fcw);
    chk("ddfs_clear", ddfs_clear, r.clr);
    chk("wave_valid", wave_valid, r.wv);
    chk("busy", busy, r.bsy);
    chk("sweep_done", sweep_done, r.dn);
    chk("cfg_ready", cfg_if.cfg_ready, r.rdy);
    if (r.sc_chk) chk("step_count", step_count, r.sc);
  endtask

  task automatic check_idle(input string tag, input bit rdy);
    chk({tag, "_fcw"}, FCW, 0);
    chk({tag, "_ddfs_clear"}, ddfs_clear, 1);
    chk({tag, "_wave_valid"}, wave_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_sweep_done"}, sweep_done, 0);
    chk({tag, "_cfg_ready"}, cfg_if.cfg_ready, rdy);
  endtask

  task automatic scramble_cfg();
    cfg_if.cfg_start_fcw = FCW_W'($urandom);
    cfg_if.cfg_stop_fcw  = FCW_W'($urandom);
    cfg_if.cfg_step      = FCW_W'($urandom);
    cfg_if.cfg_dwell     = DWELL_W'($urandom_range(0, 3));
    cfg_if.cfg_mode      = 2'($urandom);
  endtask

  // abort_sel/reset_sel: -1 none, -2 pick at random, otherwise trace index to act after.
  task automatic run_desc(input int s, input int e, input int stp, input int dw, input int md,
                          input int run_len, input int abort_sel, input int reset_sel,
                          input bit hold_valid, input bit abort_in_idle);
    int abort_at, reset_at, waited, n;
    build_model(s, e, stp, dw, md, run_len);
    n = exp_q.size();
    abort_at = abort_sel;
    reset_at = reset_sel;
    if (abort_sel == -2) abort_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
    if (reset_sel == -2) reset_at = (abort_at < 0 && $urandom_range(0, 5) == 0) ? $urandom_range(0, n - 1) : -1;
    if (exp_q[n-1].bsy && abort_at < 0 && reset_at < 0) abort_at = n - 1;
    obs_clr0 = -1; obs_wv_first = -1; obs_wv_last = -1; obs_done = -1;

    cfg_if.cfg_start_fcw = FCW_W'(s);
    cfg_if.cfg_stop_fcw  = FCW_W'(e);
    cfg_if.cfg_step      = FCW_W'(stp);
    cfg_if.cfg_dwell     = DWELL_W'(dw);
    cfg_if.cfg_mode      = 2'(md);
    cfg_if.cfg_valid     = 1'b1;
    abort                = abort_in_idle;
    waited = 0;
    while (cfg_if.cfg_ready !== 1'b1 && waited < 20) begin
      @(posedge clock_100_MHz); #1;
      waited++;
    end
    last_wait = waited;
    if (cfg_if.cfg_ready !== 1'b1) begin
      chk("cfg_ready_wait", cfg_if.cfg_ready, 1);
      cfg_if.cfg_valid = 1'b0;
      abort = 1'b0;
      return;
    end
    @(posedge clock_100_MHz); #1;
    abort = 1'b0;
    if (hold_valid) scramble_cfg();
    else            cfg_if.cfg_valid = 1'b0;

    for (int i = 0; i < n; i++) begin
      check_rec(exp_q[i]);
      if (ddfs_clear === 1'b0 && obs_clr0 < 0) obs_clr0 = i + 1;
      if (wave_valid === 1'b1) begin
        if (obs_wv_first < 0) obs_wv_first = i + 1;
        obs_wv_last = i + 1;
      end
      if (sweep_done === 1'b1 && obs_done < 0) obs_done = i + 1;
      if (!exp_q[i].bsy) cfg_if.cfg_valid = 1'b0;
      if (i == reset_at) begin
        clear_DDFS = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        @(posedge clock_100_MHz); #1;
        check_idle("reset_mid", 0);
        chk("reset_mid_step_count", step_count, 0);
        clear_DDFS = 1'b0;
        #1;
        chk("reset_mid_ready_after", cfg_if.cfg_ready, 1);
        return;
      end
      if (i == abort_at) begin
        abort = 1'b1;
        @(posedge clock_100_MHz); #1;
        abort = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        check_idle("abort", 1);
        return;
      end
      if (i < n - 1) begin
        @(posedge clock_100_MHz); #1;
      end
    end
    cfg_if.cfg_valid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, stp, dw, md, rl;
    clear_DDFS = 1'b1;
    abort      = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    scramble_cfg();
    repeat (3) @(posedge clock_100_MHz);
    #1;
    check_idle("reset", 0);
    chk("reset_step_count", step_count, 0);
    clear_DDFS = 1'b0;
    #1;
    chk("ready_after_reset", cfg_if.cfg_ready, 1);

    // Single sweep: absolute cycle landmarks relative to the capture cycle.
    run_desc(10, 40, 10, 8, 0, 0, -1, -1, 0, 0);
    chk("t1_clear_release", obs_clr0, 3);
    chk("t1_wave_first", obs_wv_first, 20);
    chk("t1_wave_last", obs_wv_last, 34);
    chk("t1_done_cycle", obs_done, 35);

    // Clamped start, downward overshoot saturating at 0.
    run_desc(400, 0, 150, 1, 0, 0, -1, -1, 0, 0);
    chk("t2_done_cycle", obs_done, 7);

    // Triangle with abort at the end; abort held during the IDLE capture is ignored.
    run_desc(100, 120, 10, 2, 2, 40, -1, -1, 0, 1);
    chk("t3_no_done", obs_done, -1);

    // Fixed tone for 1000 cycles, then repeating sweep.
    run_desc(50, 200, 0, 3, 1, 1000, -1, -1, 0, 0);
    run_desc(0, 20, 10, 1, 1, 30, -1, -1, 0, 0);

    // cfg_valid held through the sweep with dwell=0, then an immediate second capture.
    run_desc(10, 40, 10, 0, 0, 0, -1, -1, 1, 0);
    chk("t6_done_cycle", obs_done, 7);
    run_desc(30, 5, 10, 1, 0, 0, -1, -1, 0, 0);
    chk("t6_back_to_back_wait", last_wait, 0);

    // Reset during RUN at cycle 12.
    run_desc(10, 40, 10, 8, 0, 0, -1, 11, 0, 0);

    for (int t = 0; t < 40; t++) begin
      s   = $urandom_range(0, 420);
      e   = ($urandom_range(0, 7) == 0) ? s : $urandom_range(0, 420);
      stp = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(10, 200);
      dw  = $urandom_range(0, 4);
      md  = $urandom_range(0, 3);
      rl  = $urandom_range(20, 120);
      run_desc(s, e, stp, dw, md, rl, -2, -2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clock_100_MHz);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
